// File: rtl/est_pkg.sv
// Shared constants for the estimator shared-unit arbiter: state codes, channel ids, timeout default.
package est_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic CH_I = 1'b0;
  localparam logic CH_V = 1'b1;

  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } arb_state_t;

  // A lone request always wins; on contention the priority holder wins.
  function automatic logic pick_winner(input logic req_i, input logic req_v, input logic pri);
    logic win;
    win = CH_I;
    if (req_v && (!req_i || pri == CH_V)) win = CH_V;
    return win;
  endfunction

endpackage

// File: rtl/est_timeout_counter.sv
// Wait-cycle counter for the shared unit; flags terminal count at TIMEOUT-1 and holds there.
module est_timeout_counter
  import est_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Stopping at terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/est_shared_unit_arbiter.sv
// Round-robin arbiter sharing one transcendental unit between the I and V estimator channels.
//   state   | meaning
//   S_IDLE  | pick winner, latch its operand and channel
//   S_ISSUE | pulse start_u, clear timeout counter
//   S_WAIT  | wait for ack_u or terminal count
//   S_RESP  | pulse done for served channel, flip priority
module est_shared_unit_arbiter
  import est_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_i,
  input  logic         req_v,
  input  logic [N-1:0] op_i,
  input  logic [N-1:0] op_v,
  output logic         start_u,
  output logic [N-1:0] operand_u,
  input  logic         ack_u,
  input  logic [N-1:0] result_u,
  output logic         done_i,
  output logic         done_v,
  output logic [N-1:0] result,
  output logic         err_to,
  output logic         busy
);

  arb_state_t state, state_nxt;
  logic       sel;
  logic       pri;
  logic       err;
  logic       tc;
  logic       winner;
  logic       any_req;

  assign any_req = req_i | req_v;
  assign winner  = pick_winner(req_i, req_v, pri);

  est_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == S_ISSUE),
    .enable (state == S_WAIT),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ack_u || tc) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ack_u is checked before tc so a late-but-valid result is never discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= CH_I;
      pri       <= CH_I;
      err       <= 1'b0;
      operand_u <= '0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel       <= winner;
            operand_u <= (winner == CH_V) ? op_v : op_i;
          end
        end
        S_WAIT: begin
          if (ack_u) begin
            result <= result_u;
            err    <= 1'b0;
          end else if (tc) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        S_RESP:  pri <= ~sel;
        default: ;
      endcase
    end
  end

  always_comb begin
    start_u = 1'b0;
    done_i  = 1'b0;
    done_v  = 1'b0;
    err_to  = 1'b0;
    busy    = (state != S_IDLE);
    if (state == S_ISSUE) start_u = 1'b1;
    if (state == S_RESP) begin
      done_i = (sel == CH_I);
      done_v = (sel == CH_V);
      err_to = err;
    end
  end

endmodule

// File: tb/tb_est_shared_unit_arbiter.sv
// Directed bench for est_shared_unit_arbiter with TIMEOUT=8 and hand-computed expectations.
module tb_est_shared_unit_arbiter;

  localparam int N  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_i = 1'b0, req_v = 1'b0;
  logic [N-1:0] op_i = '0, op_v = '0;
  logic         start_u;
  logic [N-1:0] operand_u;
  logic         ack_u = 1'b0;
  logic [N-1:0] result_u = '0;
  logic         done_i, done_v;
  logic [N-1:0] result;
  logic         err_to, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_di   = 0;
  int cnt_dv   = 0;

  est_shared_unit_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .req_v     (req_v),
    .op_i      (op_i),
    .op_v      (op_v),
    .start_u   (start_u),
    .operand_u (operand_u),
    .ack_u     (ack_u),
    .result_u  (result_u),
    .done_i    (done_i),
    .done_v    (done_v),
    .result    (result),
    .err_to    (err_to),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_i) cnt_di++;
    if (done_v) cnt_dv++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_i = 1'b0; req_v = 1'b0; ack_u = 1'b0; result_u = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Caller has raised a request in an IDLE cycle (cycle 0). ack_u is driven d cycles
  // after the start_u cycle (d<0: never). Returns at the cycle where a done is seen.
  task automatic transact(input int d, input logic [N-1:0] res,
                          output logic [N-1:0] op_seen, output int t_start, output int t_done,
                          output logic got_i, output logic got_v,
                          output logic [N-1:0] res_seen, output logic err_seen, output bit hung);
    int c;
    int sc;
    hung = 1'b1; op_seen = '0; t_start = -1; t_done = -1;
    got_i = 1'b0; got_v = 1'b0; res_seen = '0; err_seen = 1'b0;
    c = 0;
    while (c < 20 && t_start < 0) begin
      tick(); c++;
      if (start_u) begin t_start = c; op_seen = operand_u; end
    end
    if (t_start < 0) return;
    sc = 0;
    while (sc < 40) begin
      ack_u    = (sc == d);
      result_u = (sc == d) ? res : 32'hA5A5_5A5A;
      tick(); c++; sc++;
      if (done_i || done_v) begin
        got_i = done_i; got_v = done_v; res_seen = result; err_seen = err_to;
        t_done = c; hung = 1'b0;
        break;
      end
    end
    ack_u = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] op; int ts, td; logic gi, gv, e; logic [N-1:0] r; bit h;
    do_reset();
    n_checks++;
    if ({start_u, done_i, done_v, err_to, busy, operand_u, result} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all zero");
    end
    req_i = 1'b1; op_i = 32'h1111_2222;
    transact(2, 32'hCAFE_F00D, op, ts, td, gi, gv, r, e, h);
    req_i = 1'b0;
    tick();
    req_v = 1'b1; op_v = 32'h3333_4444;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b required 1", busy); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || start_u !== 1'b0 || done_i !== 1'b0 || done_v !== 1'b0 || err_to !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wait_ctrl: got busy=%b start=%b di=%b dv=%b err=%b required all 0",
                         busy, start_u, done_i, done_v, err_to);
    end
    n_checks++;
    if (operand_u !== '0 || result !== '0) begin
      n_fail++; $display("FAIL reset_mid_wait_data: got operand=%h result=%h required 0/0", operand_u, result);
    end
    req_i = 1'b1; req_v = 1'b1;
    tick();
    rst = 1'b1;
    transact(3, 32'h0BAD_F00D, op, ts, td, gi, gv, r, e, h);
    n_checks++;
    if (h || gi !== 1'b1 || gv !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_grant: got hung=%0d di=%b dv=%b required I", h, gi, gv);
    end
    n_checks++;
    if (op !== 32'h1111_2222) begin n_fail++; $display("FAIL reset_first_operand: got %h required 11112222", op); end
    req_i = 1'b0; req_v = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [N-1:0] op; int ts, td; logic gi, gv, e; logic [N-1:0] r; bit h;
    int di0, dv0;
    do_reset();
    di0 = cnt_di; dv0 = cnt_dv;
    req_i = 1'b1; op_i = 32'h3F80_0000;
    transact(5, 32'h0000_0000, op, ts, td, gi, gv, r, e, h);
    req_i = 1'b0;
    n_checks++;
    if (op !== 32'h3F80_0000 || ts !== 1) begin
      n_fail++; $display("FAIL single_start: got operand=%h at cycle %0d required 3f800000 at 1", op, ts);
    end
    n_checks++;
    if (h || td !== 7 || gi !== 1'b1 || r !== 32'h0 || e !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got hung=%0d cycle=%0d di=%b result=%h err=%b required 7/1/0/0",
                         h, td, gi, r, e);
    end
    repeat (4) tick();
    n_checks++;
    if (cnt_di - di0 !== 1 || cnt_dv - dv0 !== 0) begin
      n_fail++; $display("FAIL single_pulses: got done_i=%0d done_v=%0d required 1 and 0", cnt_di - di0, cnt_dv - dv0);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] op; int ts, td; logic gi, gv, e; logic [N-1:0] r; bit h;
    logic exp_v;
    logic [N-1:0] exp_op;
    do_reset();
    op_i = 32'h3F80_0000; op_v = 32'hC000_0000;
    req_i = 1'b1; req_v = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_v  = (n % 2 == 1);
      exp_op = exp_v ? 32'hC000_0000 : 32'h3F80_0000;
      transact(2, 32'h1000_0000 + N'(n), op, ts, td, gi, gv, r, e, h);
      n_checks++;
      if (h || gv !== exp_v || gi !== !exp_v) begin
        n_fail++; $display("FAIL contention_grant[%0d]: got di=%b dv=%b required v=%b", n, gi, gv, exp_v);
      end
      n_checks++;
      if (op !== exp_op || r !== 32'h1000_0000 + N'(n)) begin
        n_fail++; $display("FAIL contention_data[%0d]: got operand=%h result=%h required %h/%h",
                           n, op, r, exp_op, 32'h1000_0000 + N'(n));
      end
      n_checks++;
      if (ts !== 1) begin n_fail++; $display("FAIL contention_b2b[%0d]: got start at %0d required 1", n, ts); end
      if (gi) req_i = 1'b0;
      if (gv) req_v = 1'b0;
      tick();
      req_i = 1'b1; req_v = 1'b1;
    end
    req_i = 1'b0; req_v = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] op; int ts, td; logic gi, gv, e; logic [N-1:0] r; bit h;
    do_reset();
    req_i = 1'b1; op_i = 32'h4000_0000;
    transact(3, 32'h1234_5678, op, ts, td, gi, gv, r, e, h);
    req_i = 1'b0;
    tick();
    req_v = 1'b1; op_v = 32'h4040_0000;
    transact(-1, '0, op, ts, td, gi, gv, r, e, h);
    req_v = 1'b0;
    n_checks++;
    if (h || gv !== 1'b1 || e !== 1'b1 || td !== 10) begin
      n_fail++; $display("FAIL timeout_done: got hung=%0d dv=%b err=%b cycle=%0d required 1/1/10", h, gv, e, td);
    end
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL timeout_result: got %h required 00000000", r); end
    tick();
    n_checks++;
    if (err_to !== 1'b0 || done_v !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse_end: got err=%b dv=%b busy=%b required 0/0/0", err_to, done_v, busy);
    end
    req_v = 1'b1; op_v = 32'h4080_0000;
    transact(3, 32'h3E80_0000, op, ts, td, gi, gv, r, e, h);
    req_v = 1'b0;
    n_checks++;
    if (h || gv !== 1'b1 || e !== 1'b0 || r !== 32'h3E80_0000 || op !== 32'h4080_0000 || td !== 5) begin
      n_fail++; $display("FAIL timeout_recover: got hung=%0d dv=%b err=%b result=%h operand=%h cycle=%0d",
                         h, gv, e, r, op, td);
    end
    tick();
  endtask

  task automatic test_corner();
    logic [N-1:0] op; int ts, td; logic gi, gv, e; logic [N-1:0] r; bit h;
    int di0, dv0;
    do_reset();
    req_i = 1'b1; op_i = 32'h3F00_0000;
    transact(TO, 32'h4049_0FDB, op, ts, td, gi, gv, r, e, h);
    req_i = 1'b0;
    n_checks++;
    if (h || e !== 1'b0 || r !== 32'h4049_0FDB || td !== 10 || gi !== 1'b1) begin
      n_fail++; $display("FAIL ack_at_tc: got hung=%0d err=%b result=%h cycle=%0d di=%b required 0/40490fdb/10/1",
                         h, e, r, td, gi);
    end
    tick();
    di0 = cnt_di; dv0 = cnt_dv;
    ack_u = 1'b1; result_u = 32'hFFFF_FFFF;
    repeat (3) begin
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL spurious_ack_busy: got %b required 0", busy); end
    end
    ack_u = 1'b0;
    tick();
    n_checks++;
    if (cnt_di - di0 !== 0 || cnt_dv - dv0 !== 0 || result !== 32'h4049_0FDB) begin
      n_fail++; $display("FAIL spurious_ack_done: got di=%0d dv=%0d result=%h required 0/0/40490fdb",
                         cnt_di - di0, cnt_dv - dv0, result);
    end
    req_v = 1'b1; op_v = 32'h4100_0000;
    transact(1, 32'h3DCC_CCCD, op, ts, td, gi, gv, r, e, h);
    req_v = 1'b0;
    n_checks++;
    if (h || ts !== 1 || td !== 3 || gv !== 1'b1 || r !== 32'h3DCC_CCCD) begin
      n_fail++; $display("FAIL min_latency: got hung=%0d start=%0d done=%0d dv=%b result=%h required 1/3/1/3dcccccd",
                         h, ts, td, gv, r);
    end
    tick();
    req_i = 1'b1; op_i = 32'h4120_0000;
    transact(0, 32'h7777_7777, op, ts, td, gi, gv, r, e, h);
    req_i = 1'b0;
    n_checks++;
    if (h || e !== 1'b1 || r !== 32'h0 || td !== 10 || gi !== 1'b1) begin
      n_fail++; $display("FAIL ack_in_issue: got hung=%0d err=%b result=%h cycle=%0d di=%b required 1/0/10/1",
                         h, e, r, td, gi);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
